// File: rtl/mult_sequencer.sv
// Shift-add multiplier sequencer for the CPU mult instruction: one multiplier bit per clock.
// Optional MULT_EARLY_EXIT_EN ends the run once the remaining multiplier bits are all zero.
module mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic               ovf_q;

    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_d;
    logic               last_iter;

    assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_d = mplier_q >> 1;

`ifdef MULT_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CW'(WIDTH-1)) || (mplier_d == '0);
`else
    assign last_iter = (cnt_q == CW'(WIDTH-1));
`endif

    // The start cycle itself stalls so the PC never advances past the mult.
    assign stall     = (state_q == RUN) || (start && (state_q != RUN) && !abort);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign ovf       = ovf_q;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            ovf_q       <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mcand_q  <= {{WIDTH{1'b0}}, data1};
                        mplier_q <= data2;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + 1'b1;
                    if (last_iter) begin
                        // Results take the sum including this final iteration's add.
                        result_q    <= acc_d[WIDTH-1:0];
                        result_hi_q <= acc_d[2*WIDTH-1:WIDTH];
                        ovf_q       <= |acc_d[2*WIDTH-1:WIDTH];
                        state_q     <= DONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer (WIDTH=8); honours MULT_EARLY_EXIT_EN if defined.
module tb_mult_sequencer;

    logic       CLK;
    logic       RESET_N;
    logic       start;
    logic       abort;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       stall;
    logic       done;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    mult_sequencer #(.WIDTH(8)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .start    (start),
        .abort    (abort),
        .data1    (data1),
        .data2    (data2),
        .stall    (stall),
        .done     (done),
        .result   (result),
        .result_hi(result_hi),
        .ovf      (ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advances edge by edge until done is seen; n = edges waited, st = stall-high samples before done.
    task automatic wait_done(output int n, output int st);
        n  = 0;
        st = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK);
            #1;
            n++;
            if (done) return;
            if (stall) st++;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: done=%0b after %0d edges, required done=1", done, n);
    endtask

    // Presents operands with start for one cycle; returns just after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        start = 1'b1;
        data1 = a;
        data2 = b;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        RESET_N = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        data1 = '0;
        data2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++;
        if ({stall, done, ovf, result, result_hi} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: stall=%0b done=%0b ovf=%0b result=%h hi=%h, required all 0",
                     stall, done, ovf, result, result_hi);
        end
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: stall=%0b done=%0b, required 0 0", stall, done);
        end
    endtask

    task automatic test_basic;
        int n, st;
        start = 1'b1;
        data1 = 8'd5;
        data2 = 8'd3;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL basic_start_stall: stall=%0b, required 1", stall);
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
        checks++;
        if (result !== 8'h00) begin
            errors++;
            $display("FAIL basic_result_held: result=%h, required 00", result);
        end
        wait_done(n, st);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL basic_latency: done after %0d edges, required 8", n);
        end
        checks++;
        if (st + 2 !== 9) begin
            errors++;
            $display("FAIL basic_stall_len: stall cycles %0d, required 9", st + 2);
        end
        checks++;
        if (result !== 8'h0F || result_hi !== 8'h00 || ovf !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: result=%h hi=%h ovf=%0b stall=%0b, required 0f 00 0 0",
                     result, result_hi, ovf, stall);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (done !== 1'b0 || result !== 8'h0F) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%0b result=%h, required 0 0f", done, result);
        end
    endtask

    task automatic test_back_to_back;
        int n, st;
        issue(8'hFF, 8'hFF);
        wait_done(n, st);
        checks++;
        if (result !== 8'h01 || result_hi !== 8'hFE || ovf !== 1'b1 || n !== 8) begin
            errors++;
            $display("FAIL b2b_first: result=%h hi=%h ovf=%0b edges=%0d, required 01 fe 1 8",
                     result, result_hi, ovf, n);
        end
        start = 1'b1;
        data1 = 8'd2;
        data2 = 8'd2;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_done_stall: stall=%0b, required 1", stall);
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || stall !== 1'b1 || result !== 8'h01) begin
            errors++;
            $display("FAIL b2b_accept: done=%0b stall=%0b result=%h, required 0 1 01", done, stall, result);
        end
        wait_done(n, st);
        checks++;
        if (n + 1 !== 9 || result !== 8'h04 || result_hi !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: edges=%0d result=%h hi=%h ovf=%0b, required 9 04 00 0",
                     n + 1, result, result_hi, ovf);
        end
    endtask

    task automatic test_ignore_abort;
        int n, st;
        @(posedge CLK);
        #1;
        issue(8'd7, 8'd9);
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        start = 1'b1;
        data1 = 8'd1;
        data2 = 8'd1;
        #1;
        checks++;
        if (stall !== 1'b1 || result !== 8'h04) begin
            errors++;
            $display("FAIL ignore_run_state: stall=%0b result=%h, required 1 04", stall, result);
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
        wait_done(n, st);
        checks++;
        if (n + 3 !== 8 || result !== 8'h3F || result_hi !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL ignore_start: edges=%0d result=%h hi=%h ovf=%0b, required 8 3f 00 0",
                     n + 3, result, result_hi, ovf);
        end
        @(posedge CLK);
        #1;
        issue(8'd6, 8'd7);
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        abort = 1'b1;
        @(posedge CLK);
        #1;
        abort = 1'b0;
        checks++;
        if (stall !== 1'b0 || done !== 1'b0 || result !== 8'h3F || result_hi !== 8'h00) begin
            errors++;
            $display("FAIL abort_run: stall=%0b done=%0b result=%h hi=%h, required 0 0 3f 00",
                     stall, done, result, result_hi);
        end
        n = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (done || stall) n++;
        end
        checks++;
        if (n !== 0 || result !== 8'h3F) begin
            errors++;
            $display("FAIL abort_quiet: active cycles=%0d result=%h, required 0 3f", n, result);
        end
    endtask

    task automatic test_async_reset;
        int n, st;
        issue(8'hC3, 8'h5A);
        repeat (3) @(posedge CLK);
        #3;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({stall, done, ovf, result, result_hi} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset: stall=%0b done=%0b ovf=%0b result=%h hi=%h, required all 0",
                     stall, done, ovf, result, result_hi);
        end
        repeat (2) @(posedge CLK);
        #2;
        RESET_N = 1'b1;
        n = 0;
        repeat (10) begin
            @(posedge CLK);
            #1;
            if (done || stall) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_release_idle: active cycles=%0d, required 0", n);
        end
        issue(8'h10, 8'h10);
        wait_done(n, st);
        checks++;
        if (result !== 8'h00 || result_hi !== 8'h01 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_mult: result=%h hi=%h ovf=%0b, required 00 01 1", result, result_hi, ovf);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_start_abort_same;
        int n;
        start = 1'b1;
        abort = 1'b1;
        data1 = 8'd3;
        data2 = 8'd3;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_stall: stall=%0b, required 0", stall);
        end
        @(posedge CLK);
        #1;
        start = 1'b0;
        abort = 1'b0;
        n = 0;
        repeat (10) begin
            if (done || stall) n++;
            @(posedge CLK);
            #1;
        end
        checks++;
        if (n !== 0 || result !== 8'h00 || result_hi !== 8'h01 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL start_abort_idle: active=%0d result=%h hi=%h ovf=%0b, required 0 00 01 1",
                     n, result, result_hi, ovf);
        end
    endtask

    task automatic test_short_multiplier;
        int n, st;
`ifdef MULT_EARLY_EXIT_EN
        localparam int LEN_ONE = 1;
        localparam int LEN_ZERO = 1;
`else
        localparam int LEN_ONE = 8;
        localparam int LEN_ZERO = 8;
`endif
        issue(8'hA5, 8'h01);
        wait_done(n, st);
        checks++;
        if (n !== LEN_ONE || result !== 8'hA5 || result_hi !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mplier_one: edges=%0d result=%h hi=%h ovf=%0b, required %0d a5 00 0",
                     n, result, result_hi, ovf, LEN_ONE);
        end
        @(posedge CLK);
        #1;
        issue(8'h77, 8'h00);
        wait_done(n, st);
        checks++;
        if (n !== LEN_ZERO || result !== 8'h00 || result_hi !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL mplier_zero: edges=%0d result=%h hi=%h ovf=%0b, required %0d 00 00 0",
                     n, result, result_hi, ovf, LEN_ZERO);
        end
        @(posedge CLK);
        #1;
        issue(8'h03, 8'h80);
        wait_done(n, st);
        checks++;
        if (n !== 8 || result !== 8'h80 || result_hi !== 8'h01 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL mplier_msb: edges=%0d result=%h hi=%h ovf=%0b, required 8 80 01 1",
                     n, result, result_hi, ovf);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_abort();
        test_async_reset();
        test_start_abort_same();
        test_short_multiplier();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
